fetch_buffer: RTL and testbench

- Small instruction queue between the IFU and the decode/control stage of the MIPS core.
- Accepts {PC, instruction} pairs from fetch through a valid/ready handshake, and presents them in order to decode.
- Decouples fetch from decode back-pressure. A redirect from the branch/NPC logic flushes every queued entry.

---
 rtl/fetch_buffer.sv | 86 ++++++++
 tb/tb_fetch_buffer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// In-order {pc, instr} queue between fetch and decode; flush discards all entries.
// Define FETCH_BUFFER_BYPASS_EN to forward input straight to the output when empty.
module fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             full, empty, push, pop, byp;

    always_comb begin
        full     = (cnt_q == FULL_CNT);
        empty    = (cnt_q == '0);
        in_ready = !full;
`ifdef FETCH_BUFFER_BYPASS_EN
        byp      = empty & in_valid & !flush;
`else
        byp      = 1'b0;
`endif
        out_valid = !empty | byp;
        // A bypassed pair that decode takes right away never touches storage.
        pop       = out_valid & out_ready & !empty;
        push      = in_valid & in_ready & !(byp & out_ready);
        if (!empty) begin
            {out_pc, out_instr} = mem_q[rd_ptr_q];
        end else if (byp) begin
            {out_pc, out_instr} = {in_pc, in_instr};
        end else begin
            {out_pc, out_instr} = 64'd0;
        end
        count = cnt_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= {in_pc, in_instr};
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: reset, fill/stall, wrap drain, flush, bypass.
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int n_assert = 0;
    int n_fail   = 0;

    fetch_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] pc);
        in_pc    = pc;
        in_instr = ins(pc);
    endtask

    logic [31:0] heads [6];

    initial begin
        heads = '{32'h3000, 32'h3004, 32'h3008,
                  32'h300C, 32'h3010, 32'h3014};
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; in_pc = '0; in_instr = '0;

        // asynchronous reset, checked before any clock edge
        #3 reset = 1'b1;
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_instr", 64'(out_instr), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;

        // fill with decode stalled
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put(32'h3000 + 32'(4 * i));
            #1;
            cyc();
        end
        put(32'h3010);
        #1;
        check("full_count", 64'(count), 64'd4);
        check("full_ready", 64'(in_ready), 64'd0);
        check("full_head", 64'(out_pc), 64'h3000);
        cyc();
        check("stall_count", 64'(count), 64'd4);
        check("stall_head", 64'(out_pc), 64'h3000);
        check("stall_instr", 64'(out_instr), 64'(ins(32'h3000)));

        // drain with refills, pointers wrap
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = (k < 3);
            put((k == 2) ? 32'h3014 : 32'h3010);
            #1;
            check($sformatf("drain_pc%0d", k), 64'(out_pc), 64'(heads[k]));
            check($sformatf("drain_in%0d", k), 64'(out_instr),
                  64'(ins(heads[k])));
            cyc();
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        check("empty_valid", 64'(out_valid), 64'd0);
        check("empty_pc", 64'(out_pc), 64'd0);
        check("empty_count", 64'(count), 64'd0);

        // simultaneous push and pop at count 2
        in_valid = 1'b1;
        put(32'h3100); #1; cyc();
        put(32'h3104); #1; cyc();
        check("pp_pre_count", 64'(count), 64'd2);
        check("pp_pre_head", 64'(out_pc), 64'h3100);
        put(32'h3108); out_ready = 1'b1; #1; cyc();
        in_valid = 1'b0; out_ready = 1'b0; #1;
        check("pp_count", 64'(count), 64'd2);
        check("pp_head", 64'(out_pc), 64'h3104);

        // flush with a simultaneous push and pop
        in_valid = 1'b1; put(32'h3200); #1; cyc();
        flush = 1'b1; out_ready = 1'b1; put(32'h3020); #1;
        check("fl_pre_count", 64'(count), 64'd3);
        cyc();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
        check("fl_count", 64'(count), 64'd0);
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_instr", 64'(out_instr), 64'd0);
        check("fl_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; put(32'h3040); #1; cyc();
        in_valid = 1'b0; #1;
        check("fl_next_head", 64'(out_pc), 64'h3040);
        check("fl_next_count", 64'(count), 64'd1);
        out_ready = 1'b1; #1; cyc();
        out_ready = 1'b0; #1;
        check("fl_drained", 64'(count), 64'd0);

        // latency from empty
        in_valid = 1'b1; out_ready = 1'b1; put(32'h3000); #1;
`ifdef FETCH_BUFFER_BYPASS_EN
        check("byp_valid", 64'(out_valid), 64'd1);
        check("byp_pc", 64'(out_pc), 64'h3000);
        check("byp_instr", 64'(out_instr), 64'(ins(32'h3000)));
        cyc();
        in_valid = 1'b0; out_ready = 1'b0; #1;
        check("byp_count", 64'(count), 64'd0);
        check("byp_after", 64'(out_valid), 64'd0);
`else
        check("lat_valid0", 64'(out_valid), 64'd0);
        check("lat_pc0", 64'(out_pc), 64'd0);
        cyc();
        in_valid = 1'b0; out_ready = 1'b0; #1;
        check("lat_valid1", 64'(out_valid), 64'd1);
        check("lat_pc1", 64'(out_pc), 64'h3000);
        check("lat_count1", 64'(count), 64'd1);
        out_ready = 1'b1; #1; cyc();
        out_ready = 1'b0; #1;
        check("lat_drained", 64'(count), 64'd0);
`endif

        // asynchronous reset mid-stream
        in_valid = 1'b1;
        put(32'h3300); #1; cyc();
        put(32'h3304); #1; cyc();
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_pc", 64'(out_pc), 64'd0);
        check("arst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #3 reset = 1'b0;
        in_valid = 1'b1; put(32'h3400); #1; cyc();
        in_valid = 1'b0; #1;
        check("arst_next_head", 64'(out_pc), 64'h3400);
        check("arst_next_count", 64'(count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
